// File: rtl/pipelined_f2i.sv
`timescale 1ns/1ps
// pipelined_f2i: IEEE-754 single-precision float to signed 32-bit integer.
// Unpack -> align -> round -> result select, with one valid bit per slot
// and a common enable that freezes every rank together.
module pipelined_f2i (
    input  logic        clock,
    input  logic        clr,
    input  logic        e,
    input  logic        in_valid,
    input  logic [31:0] a,
    input  logic [1:0]  rm,
    output logic [31:0] d,
    output logic        out_valid,
    output logic        invalid,
    output logic        inexact
);

    // Stage 1 (unpack) registers
    logic              s1_valid_q, s1_valid_d;
    logic              s1_sign_q,  s1_sign_d;
    logic [1:0]        s1_rm_q,    s1_rm_d;
    logic [23:0]       s1_m_q,     s1_m_d;
    logic signed [9:0] s1_e_q,     s1_e_d;
    logic              s1_nan_q,   s1_nan_d;
    logic              s1_inf_q,   s1_inf_d;
    logic              s1_zero_q,  s1_zero_d;

    // Stage 2 (align) registers
    logic              s2_valid_q, s2_valid_d;
    logic              s2_sign_q,  s2_sign_d;
    logic [1:0]        s2_rm_q,    s2_rm_d;
    logic              s2_nan_q,   s2_nan_d;
    logic              s2_ovf_q,   s2_ovf_d;
    logic [31:0]       s2_ipart_q, s2_ipart_d;
    logic              s2_r_q,     s2_r_d;
    logic              s2_s_q,     s2_s_d;

    // Stage 3 (round) registers
    logic              s3_valid_q, s3_valid_d;
    logic              s3_sign_q,  s3_sign_d;
    logic              s3_nan_q,   s3_nan_d;
    logic              s3_ovf_q,   s3_ovf_d;
    logic [31:0]       s3_mag_q,   s3_mag_d;
    logic              s3_inx_q,   s3_inx_d;

    // Output registers
    logic [31:0]       d_q,         d_d;
    logic              out_valid_q, out_valid_d;
    logic              invalid_q,   invalid_d;
    logic              inexact_q,   inexact_d;

    // Combinational scratch
    logic [7:0]        exp_f;
    logic [7:0]        exp_eff;
    logic              hidden;
    logic signed [9:0] shr_amt;
    logic signed [9:0] shr_sel;
    logic [48:0]       ext;
    logic              inc;
    logic [32:0]       mag_full;
    logic              ovf_rnd;

    // Stage 1: split the operand into sign, mantissa, unbiased exponent and class
    always_comb begin
        exp_f   = a[30:23];
        hidden  = |exp_f;
        exp_eff = hidden ? exp_f : 8'd1;
        if (e) begin
            s1_valid_d = in_valid;
            s1_sign_d  = a[31];
            s1_rm_d    = rm;
            s1_m_d     = {hidden, a[22:0]};
            s1_e_d     = $signed({2'b00, exp_eff}) - 10'sd127;
            s1_nan_d   = (&exp_f) & (|a[22:0]);
            s1_inf_d   = (&exp_f) & ~(|a[22:0]);
            s1_zero_d  = ~hidden & ~(|a[22:0]);
        end else begin
            s1_valid_d = s1_valid_q;
            s1_sign_d  = s1_sign_q;
            s1_rm_d    = s1_rm_q;
            s1_m_d     = s1_m_q;
            s1_e_d     = s1_e_q;
            s1_nan_d   = s1_nan_q;
            s1_inf_d   = s1_inf_q;
            s1_zero_d  = s1_zero_q;
        end
    end

    // Stage 2: shift the mantissa to integer alignment, keeping round and sticky bits
    always_comb begin
        s2_valid_d = s2_valid_q;
        s2_sign_d  = s2_sign_q;
        s2_rm_d    = s2_rm_q;
        s2_nan_d   = s2_nan_q;
        s2_ovf_d   = s2_ovf_q;
        s2_ipart_d = s2_ipart_q;
        s2_r_d     = s2_r_q;
        s2_s_d     = s2_s_q;
        shr_amt    = 10'sd23 - s1_e_q;
        shr_sel    = (shr_amt > 10'sd25) ? 10'sd25 : shr_amt;
        ext        = {s1_m_q, 25'd0} >> shr_sel;
        if (e) begin
            s2_valid_d = s1_valid_q;
            s2_sign_d  = s1_sign_q;
            s2_rm_d    = s1_rm_q;
            s2_nan_d   = s1_nan_q;
            s2_ovf_d   = 1'b0;
            s2_ipart_d = '0;
            s2_r_d     = 1'b0;
            s2_s_d     = 1'b0;
            if (s1_zero_q) begin
                s2_ipart_d = '0;
            end else if (s1_inf_q || s1_e_q >= 10'sd31) begin
                // -2^31 is the one exactly representable value with E = 31
                if (!s1_inf_q && s1_e_q == 10'sd31 && s1_sign_q && s1_m_q == 24'h80_0000)
                    s2_ipart_d = 32'h8000_0000;
                else
                    s2_ovf_d = 1'b1;
            end else if (s1_e_q >= 10'sd23) begin
                s2_ipart_d = {8'd0, s1_m_q} << (s1_e_q - 10'sd23);
            end else begin
                s2_ipart_d = {8'd0, ext[48:25]};
                s2_r_d     = ext[24];
                s2_s_d     = |ext[23:0];
            end
        end
    end

    // Stage 3: apply the rounding increment and detect range overflow
    always_comb begin
        case (s2_rm_q)
            2'b00:   inc = s2_r_q & (s2_s_q | s2_ipart_q[0]);
            2'b01:   inc = s2_sign_q & (s2_r_q | s2_s_q);
            2'b10:   inc = ~s2_sign_q & (s2_r_q | s2_s_q);
            default: inc = 1'b0;
        endcase
        mag_full = {1'b0, s2_ipart_q} + {32'd0, inc};
        ovf_rnd  = (~s2_sign_q & (mag_full > 33'h0_7FFF_FFFF)) |
                   ( s2_sign_q & (mag_full > 33'h0_8000_0000));
        if (e) begin
            s3_valid_d = s2_valid_q;
            s3_sign_d  = s2_sign_q;
            s3_nan_d   = s2_nan_q;
            s3_ovf_d   = s2_ovf_q | ovf_rnd;
            s3_mag_d   = mag_full[31:0];
            s3_inx_d   = s2_r_q | s2_s_q;
        end else begin
            s3_valid_d = s3_valid_q;
            s3_sign_d  = s3_sign_q;
            s3_nan_d   = s3_nan_q;
            s3_ovf_d   = s3_ovf_q;
            s3_mag_d   = s3_mag_q;
            s3_inx_d   = s3_inx_q;
        end
    end

    // Result select: NaN / saturation / signed magnitude into the output registers
    always_comb begin
        d_d         = d_q;
        out_valid_d = out_valid_q;
        invalid_d   = invalid_q;
        inexact_d   = inexact_q;
        if (e) begin
            out_valid_d = s3_valid_q;
            if (s3_nan_q) begin
                d_d       = 32'h8000_0000;
                invalid_d = 1'b1;
                inexact_d = 1'b0;
            end else if (s3_ovf_q) begin
                d_d       = s3_sign_q ? 32'h8000_0000 : 32'h7FFF_FFFF;
                invalid_d = 1'b1;
                inexact_d = 1'b0;
            end else begin
                d_d       = s3_sign_q ? (~s3_mag_q + 32'd1) : s3_mag_q;
                invalid_d = 1'b0;
                inexact_d = s3_inx_q;
            end
        end
    end

    // All ranks: synchronous clear, otherwise load the (enable-gated) next state
    always_ff @(posedge clock) begin
        if (clr) begin
            s1_valid_q  <= 1'b0;
            s1_sign_q   <= 1'b0;
            s1_rm_q     <= '0;
            s1_m_q      <= '0;
            s1_e_q      <= '0;
            s1_nan_q    <= 1'b0;
            s1_inf_q    <= 1'b0;
            s1_zero_q   <= 1'b0;
            s2_valid_q  <= 1'b0;
            s2_sign_q   <= 1'b0;
            s2_rm_q     <= '0;
            s2_nan_q    <= 1'b0;
            s2_ovf_q    <= 1'b0;
            s2_ipart_q  <= '0;
            s2_r_q      <= 1'b0;
            s2_s_q      <= 1'b0;
            s3_valid_q  <= 1'b0;
            s3_sign_q   <= 1'b0;
            s3_nan_q    <= 1'b0;
            s3_ovf_q    <= 1'b0;
            s3_mag_q    <= '0;
            s3_inx_q    <= 1'b0;
            d_q         <= '0;
            out_valid_q <= 1'b0;
            invalid_q   <= 1'b0;
            inexact_q   <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_sign_q   <= s1_sign_d;
            s1_rm_q     <= s1_rm_d;
            s1_m_q      <= s1_m_d;
            s1_e_q      <= s1_e_d;
            s1_nan_q    <= s1_nan_d;
            s1_inf_q    <= s1_inf_d;
            s1_zero_q   <= s1_zero_d;
            s2_valid_q  <= s2_valid_d;
            s2_sign_q   <= s2_sign_d;
            s2_rm_q     <= s2_rm_d;
            s2_nan_q    <= s2_nan_d;
            s2_ovf_q    <= s2_ovf_d;
            s2_ipart_q  <= s2_ipart_d;
            s2_r_q      <= s2_r_d;
            s2_s_q      <= s2_s_d;
            s3_valid_q  <= s3_valid_d;
            s3_sign_q   <= s3_sign_d;
            s3_nan_q    <= s3_nan_d;
            s3_ovf_q    <= s3_ovf_d;
            s3_mag_q    <= s3_mag_d;
            s3_inx_q    <= s3_inx_d;
            d_q         <= d_d;
            out_valid_q <= out_valid_d;
            invalid_q   <= invalid_d;
            inexact_q   <= inexact_d;
        end
    end

    assign d         = d_q;
    assign out_valid = out_valid_q;
    assign invalid   = invalid_q;
    assign inexact   = inexact_q;

endmodule

// File: tb/tb_pipelined_f2i.sv
`timescale 1ns/1ps
// Scoreboard bench for pipelined_f2i: the driver queues hand-computed results
// with their due cycle; a negedge monitor pops and compares on each enabled slot.
module tb_pipelined_f2i;

    logic        clock = 1'b0;
    logic        clr;
    logic        e;
    logic        in_valid;
    logic [31:0] a;
    logic [1:0]  rm;
    logic [31:0] d;
    logic        out_valid;
    logic        invalid;
    logic        inexact;

    pipelined_f2i dut (
        .clock     (clock),
        .clr       (clr),
        .e         (e),
        .in_valid  (in_valid),
        .a         (a),
        .rm        (rm),
        .d         (d),
        .out_valid (out_valid),
        .invalid   (invalid),
        .inexact   (inexact)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] a;
        logic [1:0]  rm;
        logic [31:0] d;
        logic        inv;
        logic        inx;
        int          due;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    logic adv   = 1'b0;

    // Edge counter and "this edge advanced the pipeline" flag
    always @(posedge clock) begin
        cyc <= cyc + 1;
        adv <= e && !clr;
    end

    // Monitor: compare each presented result against the oldest expectation
    always @(negedge clock) begin
        exp_t x;
        if (adv) begin
            if (out_valid) begin
                tests++;
                if (sb.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_output: got d=%h inv=%b inx=%b at cycle %0d, required no valid output",
                             d, invalid, inexact, cyc);
                end else begin
                    x = sb.pop_front();
                    if (d !== x.d || invalid !== x.inv || inexact !== x.inx || cyc != x.due) begin
                        fails++;
                        $display("FAIL conv a=%h rm=%b: got d=%h inv=%b inx=%b cycle=%0d, required d=%h inv=%b inx=%b cycle=%0d",
                                 x.a, x.rm, d, invalid, inexact, cyc, x.d, x.inv, x.inx, x.due);
                    end
                end
            end else if (sb.size() > 0 && sb[0].due <= cyc) begin
                tests++;
                fails++;
                x = sb.pop_front();
                $display("FAIL missing a=%h rm=%b: got no valid output at cycle %0d, required d=%h at cycle %0d",
                         x.a, x.rm, cyc, x.d, x.due);
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %h, required %h", nm, act, expv);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Present one operand for one enabled edge and queue its expected result
    task automatic issue(input logic [31:0] av, input logic [1:0] rv, input logic [31:0] dv,
                         input logic iv, input logic xv, input int extra);
        a        = av;
        rm       = rv;
        in_valid = 1'b1;
        @(posedge clock);
        #1;
        sb.push_back('{av, rv, dv, iv, xv, cyc + 3 + extra});
        in_valid = 1'b0;
    endtask

    task automatic check_outputs(input string nm, input logic [31:0] dv, input logic vv,
                                 input logic iv, input logic xv);
        chk({nm, "_d"},         d,                  dv);
        chk({nm, "_out_valid"}, {31'd0, out_valid}, {31'd0, vv});
        chk({nm, "_invalid"},   {31'd0, invalid},   {31'd0, iv});
        chk({nm, "_inexact"},   {31'd0, inexact},   {31'd0, xv});
    endtask

    initial begin
        clr      = 1'b1;
        e        = 1'b1;
        in_valid = 1'b0;
        a        = '0;
        rm       = '0;
        step();
        step();
        @(negedge clock);
        check_outputs("reset", 32'h0, 1'b0, 1'b0, 1'b0);
        step();
        clr = 1'b0;
        step();

        // Single pulse: pi, one valid output exactly 3 edges later
        issue(32'h40490FDB, 2'b00, 32'd3, 1'b0, 1'b1, 0);
        repeat (5) step();

        // Rounding modes and ties
        issue(32'h3FC00000, 2'b00, 32'd2,         1'b0, 1'b1, 0);
        issue(32'h40200000, 2'b00, 32'd2,         1'b0, 1'b1, 0);
        issue(32'hBFC00000, 2'b01, 32'hFFFFFFFE,  1'b0, 1'b1, 0);
        issue(32'hBFC00000, 2'b10, 32'hFFFFFFFF,  1'b0, 1'b1, 0);
        issue(32'hBFC00000, 2'b11, 32'hFFFFFFFF,  1'b0, 1'b1, 0);
        issue(32'h3FC00000, 2'b11, 32'd1,         1'b0, 1'b1, 0);
        // Range limits
        issue(32'h4F000000, 2'b00, 32'h7FFFFFFF,  1'b1, 1'b0, 0);
        issue(32'hCF000000, 2'b00, 32'h80000000,  1'b0, 1'b0, 0);
        issue(32'hCF000001, 2'b00, 32'h80000000,  1'b1, 1'b0, 0);
        issue(32'h7FC00000, 2'b00, 32'h80000000,  1'b1, 1'b0, 0);
        issue(32'hFF800000, 2'b00, 32'h80000000,  1'b1, 1'b0, 0);
        issue(32'h7F800000, 2'b00, 32'h7FFFFFFF,  1'b1, 1'b0, 0);
        issue(32'h4EFFFFFF, 2'b00, 32'h7FFFFF80,  1'b0, 1'b0, 0);
        // Tiny values and zeros
        issue(32'h00000001, 2'b10, 32'd1,         1'b0, 1'b1, 0);
        issue(32'h00000001, 2'b00, 32'd0,         1'b0, 1'b1, 0);
        issue(32'h80000001, 2'b01, 32'hFFFFFFFF,  1'b0, 1'b1, 0);
        issue(32'h3F000000, 2'b00, 32'd0,         1'b0, 1'b1, 0);
        issue(32'h3F400000, 2'b00, 32'd1,         1'b0, 1'b1, 0);
        issue(32'h80000000, 2'b00, 32'd0,         1'b0, 1'b0, 0);
        issue(32'h00000000, 2'b00, 32'd0,         1'b0, 1'b0, 0);
        repeat (6) step();

        // Stall: 5.0 reaches the output just before a 2-cycle freeze
        issue(32'h40A00000, 2'b00, 32'd5, 1'b0, 1'b0, 0);
        step();
        issue(32'h3F800000, 2'b00, 32'd1, 1'b0, 1'b0, 2);
        issue(32'h40000000, 2'b00, 32'd2, 1'b0, 1'b0, 2);
        e        = 1'b0;
        in_valid = 1'b1;
        a        = 32'h41100000;
        step();
        @(negedge clock);
        check_outputs("stall_hold1", 32'd5, 1'b1, 1'b0, 1'b0);
        step();
        @(negedge clock);
        check_outputs("stall_hold2", 32'd5, 1'b1, 1'b0, 1'b0);
        e        = 1'b1;
        in_valid = 1'b0;
        issue(32'h40400000, 2'b00, 32'd3, 1'b0, 1'b0, 0);
        issue(32'h40800000, 2'b00, 32'd4, 1'b0, 1'b0, 0);
        repeat (8) step();

        // Reset with three operands in flight: none of them may emerge
        a = 32'h3F800000; in_valid = 1'b1; step();
        a = 32'h40000000; step();
        a = 32'h40400000; step();
        clr      = 1'b1;
        in_valid = 1'b0;
        step();
        @(negedge clock);
        check_outputs("midreset", 32'h0, 1'b0, 1'b0, 1'b0);
        step();
        clr = 1'b0;
        issue(32'h40A00000, 2'b00, 32'd5, 1'b0, 1'b0, 0);
        repeat (6) step();

        for (int i = 0; i < 20 && sb.size() > 0; i++) step();
        if (sb.size() > 0) begin
            tests++;
            fails++;
            $display("FAIL drain: got %0d results outstanding, required 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
